space_allocator: RTL

SPACE_ALLOCATOR -- requirements
Module: space_allocator

---
 rtl/parking_pkg.sv | 20 ++
 rtl/space_allocator_if.sv | 27 ++
 rtl/free_space_encoder.sv | 23 ++
 rtl/space_allocator.sv | 106 ++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared parking-lot types and constants.
// Space count, index/timer widths and the allocator FSM states.
package parking_pkg;

  localparam int SPACES      = 8;
  localparam int GATE_CYCLES = 4;
  localparam int IDX_W       = 3;
  localparam int TIMER_W     = 8;

  typedef logic [SPACES-1:0] cap_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [TIMER_W-1:0] timer_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/space_allocator_if.sv
// Entry/exit request and status bundle of the space allocator.
// master: drives enable/exit/exit_space; slave: drives status outputs.
interface space_allocator_if;
  import parking_pkg::*;

  logic enable;
  logic exit;
  idx_t exit_space;
  cap_t parking_capacity;
  idx_t space_id;
  logic gate_open;
  logic full;
  logic error;

  modport master (
    output enable, exit, exit_space,
    input  parking_capacity, space_id,
    input  gate_open, full, error
  );

  modport slave (
    input  enable, exit, exit_space,
    output parking_capacity, space_id,
    output gate_open, full, error
  );

endinterface

// File: rtl/free_space_encoder.sv
// Lowest-index priority encoder over the free-space vector.
// vec: free bits in; idx: lowest set bit; valid: any bit set.
module free_space_encoder
  import parking_pkg::*;
(
  input  cap_t vec,
  output idx_t idx,
  output logic valid
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = SPACES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/space_allocator.sv
// Parking space allocator: admits one car per enable, drives the gate.
// Ports: clk, reset (async high), bus (space_allocator_if.slave).
module space_allocator
  import parking_pkg::*;
#(
  parameter int GATE_CYCLES = parking_pkg::GATE_CYCLES,
  parameter int SPACES      = parking_pkg::SPACES
) (
  input  logic                clk,
  input  logic                reset,
  space_allocator_if.slave    bus
);

  localparam cap_t ALL_FREE = {SPACES{1'b1}};
  localparam timer_t TLOAD  = TIMER_W'(GATE_CYCLES - 1);

  state_t state_q, state_d;
  timer_t timer_q, timer_d;
  cap_t   cap_q, cap_d;
  idx_t   id_q, id_d;
  logic   gate_q, gate_d;
  logic   full_q, full_d;
  logic   err_q, err_d;

  idx_t   enc_idx;
  logic   enc_valid;

  free_space_encoder u_enc (
    .vec   (cap_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      cap_q   <= ALL_FREE;
      id_q    <= '0;
      gate_q  <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cap_q   <= cap_d;
      id_q    <= id_d;
      gate_q  <= gate_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  // Allocation picks from the pre-update vector; an exit in the same
  // cycle only sets a bit that was 0, so it never collides with it.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cap_d   = cap_q;
    id_d    = id_q;
    gate_d  = gate_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          if (enc_valid) begin
            cap_d[enc_idx] = 1'b0;
            id_d    = enc_idx;
            gate_d  = 1'b1;
            timer_d = TLOAD;
            state_d = OPEN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      OPEN: begin
        if (timer_q == '0) begin
          gate_d  = 1'b0;
          state_d = RELEASE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      RELEASE: begin
        if (!bus.enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.exit) begin
      if (cap_q[bus.exit_space]) err_d = 1'b1;
      else cap_d[bus.exit_space] = 1'b1;
    end

    full_d = (cap_d == '0);
  end

  assign bus.parking_capacity = cap_q;
  assign bus.space_id         = id_q;
  assign bus.gate_open        = gate_q;
  assign bus.full             = full_q;
  assign bus.error            = err_q;

endmodule
